reorder_buffer: RTL
===================

// Module: reorder_buffer
// PURPOSE
//  Parametrised in-order-retire reorder buffer between decode/issue and the register file / memory controller.
//  Allocates one entry per issued instruction, accepts out-of-order CDB writebacks, retires from head in program order.
//  Drives register commit, store release to memory, and full pipeline flush on branch mispredict.
// PARAMETERS
//  DEPTH  16  entry count, power of two, >=2
//  TAG_W  4   entry index width, = $clog2(DEPTH)
//  XLEN   32  data/address width
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous active-high reset
//  alloc_valid  in   1      issue requests an entry
//  alloc_ready  out  1      entry available (count<DEPTH and no flush)
//  alloc_type   in   2      ROB_ALU/ROB_LOAD/ROB_STORE/ROB_BRANCH
//  alloc_rd     in   5      destination register
//  alloc_tag    out  TAG_W  tag assigned (= tail), valid while alloc_ready
//  wb_valid     in   1      CDB writeback
//  wb_tag       in   TAG_W  entry written
//  wb_value     in   XLEN   result / store data
//  wb_addr      in   XLEN   store address / branch redirect target
//  wb_mispred   in   1      branch resolved mispredicted
//  commit_valid out  1      one-cycle retire pulse
//  commit_we    out  1      regfile write enable (commit_valid && rd!=0)
//  commit_rd    out  5      retired rd
//  commit_tag   out  TAG_W  retired tag (regfile clears rename if equal)
//  commit_value out  XLEN   retired value
//  st_req       out  1      store request to memory controller
//  st_addr      out  XLEN   store address
//  st_data      out  XLEN   store data
//  st_ack       in   1      store accepted
//  flush        out  1      one-cycle pipeline flush pulse
//  redirect_pc  out  XLEN   fetch target, valid with flush
// BEHAVIOUR
//  Reset: head=tail=count=0, all entries invalid/not-done; all outputs 0.
//  Alloc: alloc_valid&&alloc_ready -> entry[tail]={type,rd,done=0}, tail++ (wraps mod DEPTH), count++.
//  Writeback: wb_valid to valid entry -> value/addr/mispred stored, done=1; wb to invalid entry ignored.
//  FSM: IDLE, STORE_WAIT, FLUSH.
//   IDLE: head valid&&done: ALU/LOAD -> registered commit next cycle, head++, count--;
//     STORE -> st_req=1, st_addr/st_data latched, go STORE_WAIT;
//     BRANCH !mispred -> retire, commit_valid=1 (commit_we only if rd!=0, JAL/JALR link);
//     BRANCH mispred -> retire (commit as above), flush=1, redirect_pc=addr, go FLUSH.
//   STORE_WAIT: hold st_req/addr/data until st_ack; on ack st_req=0, commit_valid=1 commit_we=0, head++, IDLE.
//   FLUSH: one cycle; all valid cleared, head=tail=count=0, ignore alloc and wb; back to IDLE.
//  Latency: wb in cycle N makes entry done at N+1; earliest commit pulse N+2. One retire per cycle max.
//  Simultaneous alloc+retire: count unchanged. Wb to head same cycle as head evaluated: retire next cycle.
//  Full: alloc_ready=0 when count==DEPTH; retire same cycle does not free slot until next cycle.
//  Empty: no retire, outputs pulse low. Reset mid-store drops st_req immediately.
// CONFIGURATION
//  ROB_FWD_EN defined: adds ports qry_tag[2] in TAG_W, qry_hit[2] out 1, qry_value[2] out XLEN;
//   combinational: hit = entry valid&&done, value = entry value (operand bypass to issue).
//   Undefined: ports absent; consumers rely on CDB/regfile only.
// STRUCTURE
//  Shared package constants: ROB_ALU/ROB_LOAD/ROB_STORE/ROB_BRANCH codes, FSM state encodings.
//  Sub-module: rob_entry_ram (DEPTH x {type,rd,value,addr,mispred}, 1W alloc, 1W wb, 1R head, 2R query).
//  Valid/done bits kept as flop vectors in the top for single-cycle flush.
// TESTING
//  Alloc 3 ALU (rd=1,2,3), wb tags 2,0,1 values 0xA,0xB,0xC -> commits rd1=0xB, rd2=0xC, rd3=0xA in order.
//  Alloc DEPTH entries, no wb -> alloc_ready=0 on 17th; retire one -> alloc_ready=1 next cycle, tail wraps to 0.
//  Store at head, wb addr=0x100 data=0x55, st_ack after 3 cycles -> st_req held 3 cycles stable, then retire.
//  Branch wb mispred addr=0x2000 with 4 younger entries -> flush 1 cycle, redirect_pc=0x2000, count=0.
//  Wb to freed tag after flush -> no state change, no commit.
//  ROB_FWD_EN: qry_tag = done entry value 0x77 -> qry_hit=1, qry_value=0x77; not-done -> qry_hit=0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: entry-type codes, retire FSM states and small helpers
// shared by the reorder buffer top and its entry storage.
package reorder_buffer_pkg;

    localparam int unsigned RD_W = 5;

    typedef enum logic [1:0] {
        ROB_ALU    = 2'd0,
        ROB_LOAD   = 2'd1,
        ROB_STORE  = 2'd2,
        ROB_BRANCH = 2'd3
    } rob_type_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_STORE_WAIT = 2'd1,
        ST_FLUSH      = 2'd2
    } rob_state_e;

    // x0 is hardwired zero, so retiring into it never writes the regfile
    function automatic logic writes_rd(input logic [RD_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/reorder_buffer_entry_ram.sv
// rob_entry_ram: per-entry payload storage for the reorder buffer.
// Alloc writes type/rd, writeback writes value/addr/mispred (disjoint fields),
// asynchronous reads for the head and, with ROB_FWD_EN, two query ports.
module rob_entry_ram
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk,
    input  logic             alloc_we,
    input  logic [TAG_W-1:0] alloc_idx,
    input  rob_type_e        alloc_type,
    input  logic [RD_W-1:0]  alloc_rd,
    input  logic             wb_we,
    input  logic [TAG_W-1:0] wb_idx,
    input  logic [XLEN-1:0]  wb_value,
    input  logic [XLEN-1:0]  wb_addr,
    input  logic             wb_mispred,
    input  logic [TAG_W-1:0] head_idx,
    output rob_type_e        head_type,
    output logic [RD_W-1:0]  head_rd,
    output logic [XLEN-1:0]  head_value,
    output logic [XLEN-1:0]  head_addr,
    output logic             head_mispred
`ifdef ROB_FWD_EN
    ,
    input  logic [TAG_W-1:0] qry_idx   [2],
    output logic [XLEN-1:0]  qry_value [2]
`endif
);

    rob_type_e       type_mem    [DEPTH];
    logic [RD_W-1:0] rd_mem      [DEPTH];
    logic [XLEN-1:0] value_mem   [DEPTH];
    logic [XLEN-1:0] addr_mem    [DEPTH];
    logic            mispred_mem [DEPTH];

    // write ports: allocation and CDB writeback touch different fields
    always_ff @(posedge clk) begin
        if (alloc_we) begin
            type_mem[alloc_idx] <= alloc_type;
            rd_mem[alloc_idx]   <= alloc_rd;
        end
        if (wb_we) begin
            value_mem[wb_idx]   <= wb_value;
            addr_mem[wb_idx]    <= wb_addr;
            mispred_mem[wb_idx] <= wb_mispred;
        end
    end

    assign head_type    = type_mem[head_idx];
    assign head_rd      = rd_mem[head_idx];
    assign head_value   = value_mem[head_idx];
    assign head_addr    = addr_mem[head_idx];
    assign head_mispred = mispred_mem[head_idx];

`ifdef ROB_FWD_EN
    // operand bypass read ports
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            qry_value[i] = value_mem[qry_idx[i]];
        end
    end
`endif

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order-retire ROB. Allocates at tail, accepts out-of-order
// writebacks, retires from head one entry per cycle, releases stores to memory
// and flushes everything on a mispredicted branch.
// Optional feature macro: ROB_FWD_EN (two combinational operand-bypass query ports).
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [1:0]       alloc_type,
    input  logic [RD_W-1:0]  alloc_rd,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [XLEN-1:0]  wb_value,
    input  logic [XLEN-1:0]  wb_addr,
    input  logic             wb_mispred,
    output logic             commit_valid,
    output logic             commit_we,
    output logic [RD_W-1:0]  commit_rd,
    output logic [TAG_W-1:0] commit_tag,
    output logic [XLEN-1:0]  commit_value,
    output logic             st_req,
    output logic [XLEN-1:0]  st_addr,
    output logic [XLEN-1:0]  st_data,
    input  logic             st_ack,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc
`ifdef ROB_FWD_EN
    ,
    input  logic [TAG_W-1:0] qry_tag   [2],
    output logic             qry_hit   [2],
    output logic [XLEN-1:0]  qry_value [2]
`endif
);

    rob_state_e       state_q, state_d;
    logic [DEPTH-1:0] valid_q, done_q;
    logic [TAG_W-1:0] head_q, tail_q;
    logic [TAG_W:0]   count_q;

    rob_type_e        head_type;
    logic [RD_W-1:0]  head_rd;
    logic [XLEN-1:0]  head_value, head_addr;
    logic             head_mispred;

    logic alloc_fire, wb_fire, head_ready;
    logic retire, commit_d, commit_we_d, st_start, st_release, flush_d;

    assign alloc_ready = (count_q != (TAG_W+1)'(DEPTH)) && (state_q != ST_FLUSH);
    assign alloc_tag   = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign wb_fire     = wb_valid && valid_q[wb_tag] && (state_q != ST_FLUSH);
    assign head_ready  = valid_q[head_q] && done_q[head_q];

    rob_entry_ram #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W),
        .XLEN (XLEN)
    ) u_ram (
        .clk         (clk),
        .alloc_we    (alloc_fire),
        .alloc_idx   (tail_q),
        .alloc_type  (rob_type_e'(alloc_type)),
        .alloc_rd    (alloc_rd),
        .wb_we       (wb_fire),
        .wb_idx      (wb_tag),
        .wb_value    (wb_value),
        .wb_addr     (wb_addr),
        .wb_mispred  (wb_mispred),
        .head_idx    (head_q),
        .head_type   (head_type),
        .head_rd     (head_rd),
        .head_value  (head_value),
        .head_addr   (head_addr),
        .head_mispred(head_mispred)
`ifdef ROB_FWD_EN
        ,
        .qry_idx     (qry_tag),
        .qry_value   (qry_value)
`endif
    );

`ifdef ROB_FWD_EN
    // bypass hit only once the producer has written back and is still in flight
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            qry_hit[i] = valid_q[qry_tag[i]] && done_q[qry_tag[i]];
        end
    end
`endif

    // retire FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // retire FSM next state and per-cycle retire decisions
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        commit_d    = 1'b0;
        commit_we_d = 1'b0;
        st_start    = 1'b0;
        st_release  = 1'b0;
        flush_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (head_ready) begin
                    unique case (head_type)
                        ROB_STORE: begin
                            st_start = 1'b1;
                            state_d  = ST_STORE_WAIT;
                        end
                        ROB_BRANCH: begin
                            retire      = 1'b1;
                            commit_d    = 1'b1;
                            commit_we_d = writes_rd(head_rd);
                            if (head_mispred) begin
                                flush_d = 1'b1;
                                state_d = ST_FLUSH;
                            end
                        end
                        ROB_ALU, ROB_LOAD: begin
                            retire      = 1'b1;
                            commit_d    = 1'b1;
                            commit_we_d = writes_rd(head_rd);
                        end
                    endcase
                end
            end
            ST_STORE_WAIT: begin
                if (st_ack) begin
                    st_release = 1'b1;
                    retire     = 1'b1;
                    commit_d   = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // registered commit, store and flush outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_we    <= 1'b0;
            commit_rd    <= '0;
            commit_tag   <= '0;
            commit_value <= '0;
            st_req       <= 1'b0;
            st_addr      <= '0;
            st_data      <= '0;
            flush        <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            commit_valid <= commit_d;
            commit_we    <= commit_we_d;
            flush        <= flush_d;
            if (commit_d) begin
                commit_rd    <= head_rd;
                commit_tag   <= head_q;
                commit_value <= head_value;
            end
            if (flush_d) redirect_pc <= head_addr;
            if (st_start) begin
                st_req  <= 1'b1;
                st_addr <= head_addr;
                st_data <= head_value;
            end else if (st_release) begin
                st_req <= 1'b0;
            end
        end
    end

    // pointers, occupancy and valid/done vectors; flush clears them in one cycle
    always_ff @(posedge clk) begin
        if (rst || state_q == ST_FLUSH) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + TAG_W'(1);
            end
            if (wb_fire) done_q[wb_tag] <= 1'b1;
            if (retire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + TAG_W'(1);
            end
            unique case ({alloc_fire, retire})
                2'b10:   count_q <= count_q + (TAG_W+1)'(1);
                2'b01:   count_q <= count_q - (TAG_W+1)'(1);
                default: ;
            endcase
        end
    end

endmodule
